// File: rtl/pipe_ctrl_unit_pkg.sv
// Shared decode types for the pipelined controller: opcode classes, mux encodings,
// the decoded control bundle and the hazard FSM states.
package ctrl_pkg;

  localparam int CTRL_ALUOP_W = 3;

  // Opcode class prefixes, matched against the top bits of the 5-bit opcode
  localparam logic [1:0] CLS_RTYPE = 2'b00;
  localparam logic [1:0] CLS_IMM   = 2'b01;
  localparam logic [2:0] CLS_MEM   = 3'b100;
  localparam logic [2:0] CLS_CJMP  = 3'b101;
  localparam logic [2:0] CLS_SHIFT = 3'b110;
  localparam logic [4:0] OPC_JMP   = 5'b11100;
  localparam logic [4:0] OPC_CALL  = 5'b11101;
  localparam logic [3:0] CLS_RET   = 4'b1111;

  localparam logic [1:0] PCSRC_NEXT   = 2'd0;
  localparam logic [1:0] PCSRC_BRANCH = 2'd1;
  localparam logic [1:0] PCSRC_JUMP   = 2'd2;
  localparam logic [1:0] PCSRC_STACK  = 2'd3;

  localparam logic [1:0] ALUSRC2_REG   = 2'd0;
  localparam logic [1:0] ALUSRC2_IMM   = 2'd1;
  localparam logic [1:0] ALUSRC2_SHAMT = 2'd2;

  localparam logic [1:0] CC_Z  = 2'b00;
  localparam logic [1:0] CC_NZ = 2'b01;
  localparam logic [1:0] CC_C  = 2'b10;
  localparam logic [1:0] CC_NC = 2'b11;

  typedef struct packed {
    logic [1:0]              alu_src2;
    logic [CTRL_ALUOP_W-1:0] alu_op;
    logic                    shift;
    logic                    reg_dt;
    logic                    mem_read;
    logic                    mem_write;
    logic                    reg_write;
    logic                    mem_to_reg;
    logic                    chg_zc;
  } ex_ctrl_t;

  typedef struct packed {
    ex_ctrl_t   ex;
    logic       cjmp;
    logic [1:0] cc;
    logic       jmp;
    logic       call;
    logic       ret;
  } ctrl_t;

  typedef enum logic {
    ST_RUN,
    ST_HAZ
  } state_t;

endpackage

// File: rtl/pipe_ctrl_unit_if.sv
// Control-unit bus: ID-stage inputs, EX flag results and all per-stage control outputs.
interface pipe_ctrl_unit_if #(
  parameter int OPC_W       = 5,
  parameter int ALUOP_W     = 3,
  parameter int STACK_DEPTH = 8
) ();
  localparam int SP_W = $clog2(STACK_DEPTH + 1);

  logic               stall;
  logic [OPC_W-1:0]   inst;
  logic               inst_valid;
  logic               alu_zero;
  logic               alu_carry;
  logic [1:0]         id_PCsrc;
  logic               id_push;
  logic               id_pop;
  logic               hold_if;
  logic               flush_if;
  logic [1:0]         ex_ALUsrc2;
  logic [ALUOP_W-1:0] ex_ALUop;
  logic               ex_shift;
  logic               ex_RegDt;
  logic               mem_MemRead;
  logic               mem_MemWrite;
  logic               wb_RegWrite;
  logic               wb_MemtoReg;
  logic               zero_flag;
  logic               carry_flag;
  logic [SP_W-1:0]    sp_level;
  logic               stack_err;

  modport master (
    output stall, inst, inst_valid, alu_zero, alu_carry,
    input  id_PCsrc, id_push, id_pop, hold_if, flush_if,
    input  ex_ALUsrc2, ex_ALUop, ex_shift, ex_RegDt,
    input  mem_MemRead, mem_MemWrite, wb_RegWrite, wb_MemtoReg,
    input  zero_flag, carry_flag, sp_level, stack_err
  );

  modport slave (
    input  stall, inst, inst_valid, alu_zero, alu_carry,
    output id_PCsrc, id_push, id_pop, hold_if, flush_if,
    output ex_ALUsrc2, ex_ALUop, ex_shift, ex_RegDt,
    output mem_MemRead, mem_MemWrite, wb_RegWrite, wb_MemtoReg,
    output zero_flag, carry_flag, sp_level, stack_err
  );
endinterface

// File: rtl/pipe_ctrl_unit_decode.sv
// Combinational opcode decoder: 5-bit opcode -> control bundle for every stage.
module ctrl_decode
  import ctrl_pkg::*;
(
  input  logic [4:0] op,
  output ctrl_t      ctrl
);

  always_comb begin
    ctrl = '0;
    if (op[4:3] == CLS_RTYPE || op[4:3] == CLS_IMM) begin
      ctrl.ex.alu_op     = op[2:0];
      ctrl.ex.alu_src2   = (op[4:3] == CLS_IMM) ? ALUSRC2_IMM : ALUSRC2_REG;
      ctrl.ex.reg_write  = 1'b1;
      ctrl.ex.mem_to_reg = 1'b1;
      ctrl.ex.chg_zc     = 1'b1;
    end else if (op[4:2] == CLS_SHIFT) begin
      ctrl.ex.alu_op     = op[2:0];
      ctrl.ex.alu_src2   = ALUSRC2_SHAMT;
      ctrl.ex.shift      = 1'b1;
      ctrl.ex.reg_write  = 1'b1;
      ctrl.ex.mem_to_reg = 1'b1;
      ctrl.ex.chg_zc     = 1'b1;
    end else if (op[4:2] == CLS_MEM) begin
      ctrl.ex.alu_src2 = ALUSRC2_IMM;
      ctrl.ex.reg_dt   = 1'b1;
      if (op[0]) begin
        ctrl.ex.mem_write = 1'b1;
      end else begin
        ctrl.ex.mem_read  = 1'b1;
        ctrl.ex.reg_write = 1'b1;
      end
    end else if (op[4:2] == CLS_CJMP) begin
      ctrl.cjmp = 1'b1;
      ctrl.cc   = op[1:0];
    end else if (op == OPC_JMP) begin
      ctrl.jmp = 1'b1;
    end else if (op == OPC_CALL) begin
      ctrl.call = 1'b1;
    end else if (op[4:1] == CLS_RET) begin
      ctrl.ret = 1'b1;
    end
  end

endmodule

// File: rtl/pipe_ctrl_unit.sv
// Pipelined control unit: ID decode, ID/EX-EX/MEM-MEM/WB control registers, Z/C flags,
// flag-hazard FSM and call-stack tracking. PIPE_CTRL_FLAG_FWD_EN forwards EX flags to ID.
module pipe_ctrl_unit
  import ctrl_pkg::*;
#(
  parameter int OPC_W       = 5,
  parameter int ALUOP_W     = 3,
  parameter int STACK_DEPTH = 8
) (
  input logic             clk,
  input logic             rst,
  pipe_ctrl_unit_if.slave bus
);

  localparam int SP_W = $clog2(STACK_DEPTH + 1);
  localparam logic [SP_W-1:0] SP_FULL = SP_W'(STACK_DEPTH);

  ctrl_t           id_ctrl;
  ex_ctrl_t        ex_q, ex_d;
  logic            mem_rd_q, mem_wr_q, mem_rw_q, mem_m2r_q;
  logic            wb_rw_q, wb_m2r_q;
  logic            zf_q, cf_q, err_q;
  logic [SP_W-1:0] sp_q;
  state_t          state_q, state_d;

  logic       haz_cand, haz, zf_use, cf_use, taken;
  logic       push, pop, err_set;
  logic [1:0] pcsrc;

  ctrl_decode u_decode (
    .op   (bus.inst[OPC_W-1 -: 5]),
    .ctrl (id_ctrl)
  );

  always_comb begin
    haz_cand = 1'b0;
    zf_use   = zf_q;
    cf_use   = cf_q;
`ifdef PIPE_CTRL_FLAG_FWD_EN
    if (ex_q.chg_zc) begin
      zf_use = bus.alu_zero;
      cf_use = bus.alu_carry;
    end
`else
    haz_cand = bus.inst_valid && id_ctrl.cjmp && ex_q.chg_zc;
`endif
    // In HAZ the writer has retired into the flags, so the jump resolves normally
    haz = haz_cand && (state_q == ST_RUN);

    case (id_ctrl.cc)
      CC_Z:    taken = zf_use;
      CC_NZ:   taken = !zf_use;
      CC_C:    taken = cf_use;
      default: taken = !cf_use;
    endcase

    pcsrc   = PCSRC_NEXT;
    push    = 1'b0;
    pop     = 1'b0;
    err_set = 1'b0;
    if (bus.inst_valid && !haz) begin
      if (id_ctrl.cjmp && taken) pcsrc = PCSRC_BRANCH;
      if (id_ctrl.jmp) pcsrc = PCSRC_JUMP;
      if (id_ctrl.call) begin
        pcsrc = PCSRC_JUMP;
        if (sp_q < SP_FULL) push = 1'b1;
        else                err_set = 1'b1;
      end
      if (id_ctrl.ret) begin
        if (sp_q != '0) begin
          pcsrc = PCSRC_STACK;
          pop   = 1'b1;
        end else begin
          err_set = 1'b1;
        end
      end
    end

    ex_d    = (bus.inst_valid && !haz) ? id_ctrl.ex : '0;
    state_d = haz ? ST_HAZ : ST_RUN;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ex_q      <= '0;
      mem_rd_q  <= 1'b0;
      mem_wr_q  <= 1'b0;
      mem_rw_q  <= 1'b0;
      mem_m2r_q <= 1'b0;
      wb_rw_q   <= 1'b0;
      wb_m2r_q  <= 1'b0;
      zf_q      <= 1'b0;
      cf_q      <= 1'b0;
      sp_q      <= '0;
      err_q     <= 1'b0;
      state_q   <= ST_RUN;
    end else if (!bus.stall) begin
      ex_q      <= ex_d;
      mem_rd_q  <= ex_q.mem_read;
      mem_wr_q  <= ex_q.mem_write;
      mem_rw_q  <= ex_q.reg_write;
      mem_m2r_q <= ex_q.mem_to_reg;
      wb_rw_q   <= mem_rw_q;
      wb_m2r_q  <= mem_m2r_q;
      if (ex_q.chg_zc) begin
        zf_q <= bus.alu_zero;
        cf_q <= bus.alu_carry;
      end
      if (push)     sp_q <= sp_q + SP_W'(1);
      else if (pop) sp_q <= sp_q - SP_W'(1);
      if (err_set) err_q <= 1'b1;
      state_q <= state_d;
    end
  end

  assign bus.id_PCsrc     = pcsrc;
  assign bus.id_push      = push;
  assign bus.id_pop       = pop;
  assign bus.hold_if      = haz;
  assign bus.flush_if     = !bus.stall && (pcsrc != PCSRC_NEXT);
  assign bus.ex_ALUsrc2   = ex_q.alu_src2;
  assign bus.ex_ALUop     = ALUOP_W'(ex_q.alu_op);
  assign bus.ex_shift     = ex_q.shift;
  assign bus.ex_RegDt     = ex_q.reg_dt;
  assign bus.mem_MemRead  = mem_rd_q;
  assign bus.mem_MemWrite = mem_wr_q;
  assign bus.wb_RegWrite  = wb_rw_q;
  assign bus.wb_MemtoReg  = wb_m2r_q;
  assign bus.zero_flag    = zf_q;
  assign bus.carry_flag   = cf_q;
  assign bus.sp_level     = sp_q;
  assign bus.stack_err    = err_q;

endmodule
